// File: rtl/fpu_dp_issue.sv
// fpu_dp_issue: queues FPU commands in a FIFO and issues them one at a time to an external FPU, returning each result with its flags
module fpu_dp_issue #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic [WIDTH-1:0] fpu_A,
  output logic [WIDTH-1:0] fpu_B,
  output logic [1:0]       fpu_OpCode,
  input  logic [WIDTH-1:0] fpu_Result,
  input  logic             fpu_Overflow,
  input  logic             fpu_Underflow,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_overflow,
  output logic             rsp_underflow,
  output logic [1:0]       rsp_op,
  output logic             busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int NW = AW + 1;
  localparam int CW = $clog2(LATENCY + 1);
  localparam int EW = 2 * WIDTH + 2;
  typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;
  state_t state_q, state_d;
  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] head;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [NW-1:0] count_q, count_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [1:0] op_q, op_d, rop_q, rop_d;
  logic ovf_q, ovf_d, unf_q, unf_d;
  logic push, pop, cap;
  always_comb begin
    head = mem_q[rd_ptr_q];
    push = cmd_valid && cmd_ready;
    pop = (state_q == IDLE) && (count_q != '0);
    cap = (state_q == RUN) && (cnt_q == '0);
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d = count_q + NW'(push) - NW'(pop);
    {op_d, a_d, b_d} = pop ? head : {op_q, a_q, b_q};
    cnt_d = pop ? CW'(LATENCY) : (state_q == RUN && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    {rop_d, res_d, ovf_d, unf_d} = cap ? {op_q, fpu_Result, fpu_Overflow, fpu_Underflow}
                                       : {rop_q, res_q, ovf_q, unf_q};
    state_d = pop ? RUN : cap ? RESP : (state_q == RESP && rsp_ready) ? IDLE : state_q;
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_op, cmd_a, cmd_b};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      res_q    <= '0;
      rop_q    <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      res_q    <= res_d;
      rop_q    <= rop_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end
  assign cmd_ready = count_q != NW'(DEPTH);
  assign fpu_A = a_q;
  assign fpu_B = b_q;
  assign fpu_OpCode = op_q;
  assign rsp_valid = state_q == RESP;
  assign rsp_result = res_q;
  assign rsp_overflow = ovf_q;
  assign rsp_underflow = unf_q;
  assign rsp_op = rop_q;
  assign busy = (count_q != '0) || (state_q != IDLE);
endmodule

// File: tb/tb_fpu_dp_issue.sv
// tb_fpu_dp_issue: directed self-checking bench for fpu_dp_issue with double-precision FPU stubs of latency 1 and 3
module tb_fpu_dp_issue;
  logic clk = 0;
  logic rst_n = 1;
  always #5 clk = ~clk;
  int tests = 0;
  int fails = 0;
  int sent = 0;
  int got = 0;
  logic cmd_valid = 0, rsp_ready = 0, cmd_ready, rsp_valid, rsp_overflow, rsp_underflow, busy;
  logic fpu_Overflow, fpu_Underflow;
  logic [1:0] cmd_op = 0, fpu_OpCode, rsp_op;
  logic [63:0] cmd_a = 0, cmd_b = 0, fpu_A, fpu_B, fpu_Result, rsp_result;
  logic cmd_valid_3 = 0, rsp_ready_3 = 0, cmd_ready_3, rsp_valid_3, rsp_overflow_3, rsp_underflow_3, busy_3;
  logic fpu_Overflow_3, fpu_Underflow_3;
  logic [1:0] cmd_op_3 = 0, fpu_OpCode_3, rsp_op_3;
  logic [63:0] cmd_a_3 = 0, cmd_b_3 = 0, fpu_A_3, fpu_B_3, fpu_Result_3, rsp_result_3;
  logic [1:0] ops [10] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd3};
  logic [15:0] as [10] = '{16'h3FF0, 16'h4014, 16'h4000, 16'h4020, 16'h4008, 16'h4020, 16'h4010, 16'h4018, 16'h3FE0, 16'h3FF0};
  logic [15:0] bs [10] = '{16'h4000, 16'h3FF0, 16'h4008, 16'h4000, 16'h4010, 16'h4008, 16'h4010, 16'h4008, 16'h4020, 16'h4000};
  logic [15:0] rs [10] = '{16'h4008, 16'h4010, 16'h4018, 16'h4010, 16'h401C, 16'h4014, 16'h4030, 16'h4000, 16'h4010, 16'h3FE0};
  fpu_dp_issue u_dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .fpu_A(fpu_A), .fpu_B(fpu_B), .fpu_OpCode(fpu_OpCode),
    .fpu_Result(fpu_Result), .fpu_Overflow(fpu_Overflow), .fpu_Underflow(fpu_Underflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_overflow(rsp_overflow), .rsp_underflow(rsp_underflow), .rsp_op(rsp_op), .busy(busy)
  );
  fpu_dp_issue #(.LATENCY(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid_3), .cmd_ready(cmd_ready_3), .cmd_op(cmd_op_3),
    .cmd_a(cmd_a_3), .cmd_b(cmd_b_3), .fpu_A(fpu_A_3), .fpu_B(fpu_B_3), .fpu_OpCode(fpu_OpCode_3),
    .fpu_Result(fpu_Result_3), .fpu_Overflow(fpu_Overflow_3), .fpu_Underflow(fpu_Underflow_3),
    .rsp_valid(rsp_valid_3), .rsp_ready(rsp_ready_3), .rsp_result(rsp_result_3),
    .rsp_overflow(rsp_overflow_3), .rsp_underflow(rsp_underflow_3), .rsp_op(rsp_op_3), .busy(busy_3)
  );
  function automatic logic [65:0] fpu_model(logic [1:0] op, logic [63:0] a, logic [63:0] b);
    real x, y, z;
    logic [63:0] r;
    x = $bitstoreal(a);
    y = $bitstoreal(b);
    z = op == 2'd0 ? x + y : op == 2'd1 ? x - y : op == 2'd2 ? x * y : x / y;
    r = $realtobits(z);
    return {r[62:52] == 11'h7FF, r[62:52] == 11'h0 && r[51:0] != 52'h0, r};
  endfunction
  logic [65:0] s1, t1, t2, t3;
  always @(posedge clk) begin
    s1 <= fpu_model(fpu_OpCode, fpu_A, fpu_B);
    t1 <= fpu_model(fpu_OpCode_3, fpu_A_3, fpu_B_3);
    t2 <= t1;
    t3 <= t2;
  end
  assign {fpu_Overflow, fpu_Underflow, fpu_Result} = s1;
  assign {fpu_Overflow_3, fpu_Underflow_3, fpu_Result_3} = t3;
  function automatic logic [63:0] d(logic [15:0] h);
    return {h, 48'h0};
  endfunction
  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic set_cmd(int i);
    cmd_valid = 1;
    cmd_op = ops[i];
    cmd_a = d(as[i]);
    cmd_b = d(bs[i]);
  endtask
  task automatic run_one(logic [1:0] op, logic [63:0] a, logic [63:0] b);
    cmd_valid = 1;
    cmd_op = op;
    cmd_a = a;
    cmd_b = b;
    tick();
    cmd_valid = 0;
    for (int i = 0; i < 20 && !rsp_valid; i++) tick();
    check("run_one rsp_valid", rsp_valid, 1);
  endtask
  task automatic stream(int n, bit rnd);
    for (int cyc = 0; cyc < 400 && got < n; cyc++) begin
      cmd_valid = sent < n;
      if (sent < n) set_cmd(sent);
      rsp_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rsp_valid && rsp_ready) begin
        check("stream result", rsp_result, d(rs[got]));
        check("stream op", rsp_op, ops[got]);
        got++;
      end
      if (cmd_valid && cmd_ready) sent++;
      tick();
    end
    check("stream count", got, n);
    cmd_valid = 0;
    rsp_ready = 0;
    tick(2);
    check("stream idle busy", busy, 0);
    check("stream idle rsp_valid", rsp_valid, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic seen;
    #2 rst_n = 0;
    #1;
    check("reset cmd_ready", cmd_ready, 1);
    check("reset busy", busy, 0);
    check("reset rsp_valid", rsp_valid, 0);
    check("reset fpu_A", fpu_A, 0);
    check("reset rsp_result", rsp_result, 0);
    tick(2);
    rst_n = 1;
    tick();
    set_cmd(0);
    tick();
    cmd_valid = 0;
    check("add e0 busy", busy, 1);
    check("add e0 rsp_valid", rsp_valid, 0);
    tick();
    check("add e1 fpu_A", fpu_A, 64'h3FF0_0000_0000_0000);
    check("add e1 fpu_B", fpu_B, 64'h4000_0000_0000_0000);
    check("add e1 fpu_OpCode", fpu_OpCode, 0);
    check("add e1 rsp_valid", rsp_valid, 0);
    tick();
    check("add e2 rsp_valid", rsp_valid, 0);
    tick();
    check("add e3 rsp_valid", rsp_valid, 1);
    check("add e3 rsp_result", rsp_result, 64'h4008_0000_0000_0000);
    check("add e3 rsp_op", rsp_op, 0);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    check("add e4 rsp_valid", rsp_valid, 0);
    check("add e4 busy", busy, 0);
    run_one(2'd2, 64'h7FE0_0000_0000_0000, d(16'h4000));
    check("ovf result", rsp_result, 64'h7FF0_0000_0000_0000);
    check("ovf overflow", rsp_overflow, 1);
    check("ovf underflow", rsp_underflow, 0);
    check("ovf op", rsp_op, 2);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    run_one(2'd3, 64'h0010_0000_0000_0000, d(16'h4010));
    check("unf result", rsp_result, 64'h0004_0000_0000_0000);
    check("unf overflow", rsp_overflow, 0);
    check("unf underflow", rsp_underflow, 1);
    check("unf op", rsp_op, 3);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    sent = 0;
    got = 0;
    for (int c = 0; c < 6; c++) begin
      logic acc;
      set_cmd(sent);
      check("fill cmd_ready", cmd_ready, c < 5);
      acc = cmd_ready;
      tick();
      if (acc) sent++;
    end
    check("fill accepted", sent, 5);
    check("fill rsp_valid", rsp_valid, 1);
    check("fill rsp_result", rsp_result, d(rs[0]));
    for (int c = 0; c < 3; c++) begin
      tick();
      check("stall cmd_ready", cmd_ready, 0);
      check("stall rsp_result", rsp_result, d(rs[0]));
      check("stall rsp_op", rsp_op, ops[0]);
    end
    stream(6, 0);
    sent = 0;
    got = 0;
    stream(10, 1);
    rsp_ready = 1;
    for (int c = 0; c < 5; c++) begin
      set_cmd(c);
      tick();
    end
    cmd_valid = 0;
    tick();
    check("midop running fpu_A", fpu_A, d(as[1]));
    check("midop running busy", busy, 1);
    #2 rst_n = 0;
    #1;
    check("midop rsp_valid", rsp_valid, 0);
    check("midop busy", busy, 0);
    check("midop cmd_ready", cmd_ready, 1);
    check("midop fpu_A", fpu_A, 0);
    check("midop fpu_B", fpu_B, 0);
    check("midop fpu_OpCode", fpu_OpCode, 0);
    check("midop rsp_result", rsp_result, 0);
    check("midop rsp_op", rsp_op, 0);
    check("midop rsp_flags", {rsp_overflow, rsp_underflow}, 0);
    @(negedge clk);
    rst_n = 1;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      seen |= rsp_valid | busy;
    end
    check("midop quiet after reset", seen, 0);
    rsp_ready = 0;
    cmd_valid_3 = 1;
    cmd_op_3 = 2'd2;
    cmd_a_3 = d(16'h4008);
    cmd_b_3 = d(16'h4010);
    tick();
    cmd_valid_3 = 0;
    for (int e = 1; e <= 5; e++) begin
      tick();
      check("lat3 rsp_valid", rsp_valid_3, e >= 5);
      check("lat3 fpu_A", fpu_A_3, d(16'h4008));
      check("lat3 fpu_B", fpu_B_3, d(16'h4010));
    end
    check("lat3 rsp_result", rsp_result_3, d(16'h4028));
    check("lat3 rsp_op", rsp_op_3, 2);
    rsp_ready_3 = 1;
    tick();
    rsp_ready_3 = 0;
    check("lat3 rsp_valid drop", rsp_valid_3, 0);
    check("lat3 fpu_A hold", fpu_A_3, d(16'h4008));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fpu_dp_issue.md
FPU_DP_ISSUE -- requirements
Module: fpu_dp_issue

Interface
REQ-001 The block SHALL have parameter WIDTH, default 64, giving the operand/result width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the command FIFO depth in entries; DEPTH is a power of 2 and at least 2.
REQ-003 The block SHALL have parameter LATENCY, default 1, giving the FPU clock edges from stable inputs to valid Result; LATENCY is at least 1.
REQ-004 The block SHALL have one clock and an asynchronous active-low reset, with ports listed below in order.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous reset, active low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command FIFO can accept.
- cmd_op  in  2  00 add, 01 sub, 10 mul, 11 div.
- cmd_a  in  WIDTH  operand A.
- cmd_b  in  WIDTH  operand B.
- fpu_A  out  WIDTH  drives FPU operand A.
- fpu_B  out  WIDTH  drives FPU operand B.
- fpu_OpCode  out  2  drives FPU OpCode.
- fpu_Result  in  WIDTH  FPU result.
- fpu_Overflow  in  1  FPU overflow flag.
- fpu_Underflow  in  1  FPU underflow flag.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  downstream accepts response.
- rsp_result  out  WIDTH  captured result.
- rsp_overflow  out  1  captured overflow flag.
- rsp_underflow  out  1  captured underflow flag.
- rsp_op  out  2  opcode of the response.
- busy  out  1  FIFO non-empty or FSM not IDLE.

Function
REQ-005 The FIFO SHALL push {cmd_op, cmd_a, cmd_b} on an edge where cmd_valid and cmd_ready are both 1.
REQ-006 cmd_ready SHALL equal NOT full, evaluated from registered count only; a pop in the same cycle SHALL NOT raise cmd_ready when full.
REQ-007 Read and write pointers SHALL wrap modulo DEPTH; count SHALL range from 0 to DEPTH; a simultaneous push and pop SHALL leave count unchanged.
REQ-008 The FSM SHALL have exactly three states: IDLE, RUN and RESP.
REQ-009 IDLE: on an edge with FIFO non-empty, the FSM SHALL pop the head into operand registers, set cnt to LATENCY and go to RUN; the FSM SHALL NOT bypass from push to pop in the same edge.
REQ-010 fpu_A, fpu_B and fpu_OpCode SHALL be driven from the operand registers and SHALL stay stable from the pop edge until the next pop.
REQ-011 RUN: while cnt is not 0, the FSM SHALL decrement cnt each edge.
REQ-012 RUN: on the edge where cnt is 0, the FSM SHALL capture fpu_Result, fpu_Overflow, fpu_Underflow and the opcode into rsp_* registers and go to RESP.
REQ-013 Latency: rsp_valid SHALL rise after the (LATENCY+2)th edge following command acceptance when the FIFO is empty and the FSM is IDLE at acceptance.
REQ-014 RESP: rsp_valid SHALL be 1 and rsp_* SHALL be held stable until an edge with rsp_ready=1.
REQ-015 On that rsp_ready edge the FSM SHALL go to IDLE, and rsp_valid SHALL fall in the same edge.
REQ-016 At most one operation SHALL be in flight; sustained throughput SHALL be one command per LATENCY+3 cycles with rsp_ready held at 1.
REQ-017 The FIFO SHALL keep accepting commands while the FSM is in RUN or RESP; rsp_ready back-pressure SHALL only stall the FIFO.
REQ-018 Operand and result values SHALL pass through unmodified; the block SHALL NOT detect special values (NaN, INF, zero).
REQ-019 busy SHALL equal (count != 0) OR (state != IDLE).

Reset
REQ-020 rst_n low SHALL, asynchronously, set state to IDLE, pointers, count and cnt to 0, and FIFO contents to don't-care.
REQ-021 rst_n low SHALL set fpu_A, fpu_B, fpu_OpCode, rsp_result, rsp_op, rsp_overflow, rsp_underflow and rsp_valid to 0, with cmd_ready=1 and busy=0.
REQ-022 Reset asserted mid-operation SHALL discard the in-flight operation and all queued commands without emitting any response.

Verification
REQ-023 Single add: with an FPU stub of latency 1, push op=00, A=0x3FF0000000000000, B=0x4000000000000000 at edge 0 -> rsp_valid rises after edge 3, rsp_result=0x4008000000000000, rsp_op=00.
REQ-024 Fill: hold rsp_ready=0 and offer 6 commands back-to-back -> 1 command popped into RUN, then cmd_ready falls when count reaches 4; rsp data SHALL stay constant while stalled.
REQ-025 Order and wrap: issue 10 commands with distinct operands and random rsp_ready -> 10 responses, in order, opcodes matched, no loss or duplication.
REQ-026 Flags: stub asserts fpu_Overflow=1 for mul 0x7FE0000000000000 x 2.0 -> rsp_overflow=1, rsp_underflow=0, rsp_op=10.
REQ-027 Mid-op reset: pulse rst_n low during RUN with 3 queued commands -> all outputs at reset values immediately, no rsp_valid afterwards, busy=0.
REQ-028 LATENCY=3 build: single command -> rsp_valid rises after edge 5 and fpu_* stay stable throughout.
